// File: rtl/bomb_pkg.sv
// Shared bomb definitions: FSM state encoding, tile geometry and default frame timings.
// The bitmap and collision blocks use the same definitions.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_EXPLODING = 2'd2,
    ST_COOLDOWN  = 2'd3
  } bomb_state_e;

  localparam int unsigned TILE_BITS = 5;
  localparam int unsigned TILE_SIZE = 32;

  localparam int unsigned DEF_FUSE_FRAMES     = 180;
  localparam int unsigned DEF_FLAME_FRAMES    = 30;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 10;
  localparam int unsigned DEF_WARN_FRAMES     = 60;

  localparam logic [10:0] TILE_MASK = ~((11'd1 << TILE_BITS) - 11'd1);

  // Rounds a sprite top-left to the tile under its centre; 11-bit overflow wraps.
  function automatic logic [10:0] snap_to_tile(input logic [10:0] p);
    logic [10:0] s;
    s = p + 11'(TILE_SIZE / 2);
    return s & TILE_MASK;
  endfunction

  function automatic logic [10:0] flame_origin(input logic [10:0] b);
    logic [10:0] r;
    if (b < 11'(TILE_SIZE)) begin
      r = 11'd0;
    end else begin
      r = b - 11'(TILE_SIZE);
    end
    return r;
  endfunction

endpackage

// File: rtl/bomb_fuse_ctrl_frame_timer.sv
// Loadable 8-bit frame down-counter, shared by the fuse, flame and cooldown phases.
module frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_next,
  output logic       done
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: a load wins over a decrement arriving in the same cycle.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && startOfFrame) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;
  assign done       = en && startOfFrame && (count_q == 8'd1);

endmodule

// File: rtl/bomb_fuse_ctrl.sv
// Single-bomb lifecycle: placement, fuse countdown, explosion, cooldown.
// All outputs are registered from next-state values.
module bomb_fuse_ctrl
  import bomb_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES     = DEF_FUSE_FRAMES,
  parameter int unsigned FLAME_FRAMES    = DEF_FLAME_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int unsigned WARN_FRAMES     = DEF_WARN_FRAMES
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        place_req,
  input  logic [10:0] playerX,
  input  logic [10:0] playerY,
  input  logic        chain_hit,
  output logic        place_ack,
  output logic        bomb_exist,
  output logic        bomb_exploded,
  output logic        bomb_blink,
  output logic        explode_pulse,
  output logic [10:0] bombTopLeftX,
  output logic [10:0] bombTopLeftY,
  output logic [10:0] flameHTopLeftX,
  output logic [10:0] flameVTopLeftY
);

  localparam logic [7:0] FUSE_L  = 8'(FUSE_FRAMES);
  localparam logic [7:0] FLAME_L = 8'(FLAME_FRAMES);
  localparam logic [7:0] COOL_L  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] WARN_L  = 8'(WARN_FRAMES);

  bomb_state_e state_q, state_d;
  logic        t_en, t_load, t_done;
  logic [7:0]  t_load_val, t_count_next;

  logic        place_ack_q, place_ack_d;
  logic        exist_q, exist_d;
  logic        exploded_q, exploded_d;
  logic        blink_q, blink_d;
  logic        pulse_q, pulse_d;
  logic [10:0] bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
  logic [10:0] flame_h_q, flame_h_d, flame_v_q, flame_v_d;

  frame_timer u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .en           (t_en),
    .load         (t_load),
    .load_val     (t_load_val),
    .count_next   (t_count_next),
    .done         (t_done)
  );

  // Lifecycle FSM and timer control; each phase reloads the timer as it is entered.
  always_comb begin
    state_d     = state_q;
    t_en        = 1'b0;
    t_load      = 1'b0;
    t_load_val  = 8'd0;
    place_ack_d = 1'b0;
    bomb_x_d    = bomb_x_q;
    bomb_y_d    = bomb_y_q;
    case (state_q)
      ST_IDLE: begin
        if (place_req) begin
          state_d     = ST_ARMED;
          t_load      = 1'b1;
          t_load_val  = FUSE_L;
          place_ack_d = 1'b1;
          bomb_x_d    = snap_to_tile(playerX);
          bomb_y_d    = snap_to_tile(playerY);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        t_en = 1'b1;
        if (chain_hit || t_done) begin
          state_d    = ST_EXPLODING;
          t_load     = 1'b1;
          t_load_val = FLAME_L;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_EXPLODING: begin
        t_en = 1'b1;
        if (t_done) begin
          state_d    = ST_COOLDOWN;
          t_load     = 1'b1;
          t_load_val = COOL_L;
        end else begin
          state_d = ST_EXPLODING;
        end
      end
      ST_COOLDOWN: begin
        t_en = 1'b1;
        if (t_done) begin
          state_d    = ST_IDLE;
          t_load     = 1'b1;
          t_load_val = 8'd0;
        end else begin
          state_d = ST_COOLDOWN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        t_load     = 1'b1;
        t_load_val = 8'd0;
      end
    endcase
  end

  // Output values derived from the upcoming state so the registers track it exactly.
  always_comb begin
    exist_d    = (state_d == ST_ARMED) || (state_d == ST_EXPLODING);
    exploded_d = (state_d == ST_EXPLODING);
    pulse_d    = (state_q == ST_ARMED) && (state_d == ST_EXPLODING);
    flame_h_d  = flame_origin(bomb_x_d);
    flame_v_d  = flame_origin(bomb_y_d);
    if ((state_d == ST_ARMED) && (t_count_next <= WARN_L)) begin
      blink_d = t_count_next[3];
    end else begin
      blink_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      place_ack_q <= 1'b0;
      exist_q     <= 1'b0;
      exploded_q  <= 1'b0;
      blink_q     <= 1'b1;
      pulse_q     <= 1'b0;
      bomb_x_q    <= 11'd0;
      bomb_y_q    <= 11'd0;
      flame_h_q   <= 11'd0;
      flame_v_q   <= 11'd0;
    end else begin
      state_q     <= state_d;
      place_ack_q <= place_ack_d;
      exist_q     <= exist_d;
      exploded_q  <= exploded_d;
      blink_q     <= blink_d;
      pulse_q     <= pulse_d;
      bomb_x_q    <= bomb_x_d;
      bomb_y_q    <= bomb_y_d;
      flame_h_q   <= flame_h_d;
      flame_v_q   <= flame_v_d;
    end
  end

  assign place_ack      = place_ack_q;
  assign bomb_exist     = exist_q;
  assign bomb_exploded  = exploded_q;
  assign bomb_blink     = blink_q;
  assign explode_pulse  = pulse_q;
  assign bombTopLeftX   = bomb_x_q;
  assign bombTopLeftY   = bomb_y_q;
  assign flameHTopLeftX = flame_h_q;
  assign flameVTopLeftY = flame_v_q;

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Directed bench for bomb_fuse_ctrl: three parameterisations share one stimulus bus,
// each test resets and then checks only the instance it targets.
module tb_bomb_fuse_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        sof = 1'b0;
  logic        place_req = 1'b0;
  logic        chain_hit = 1'b0;
  logic [10:0] px = 11'd0;
  logic [10:0] py = 11'd0;

  logic s_ack, s_exist, s_expl, s_blink, s_pulse;
  logic [10:0] s_bx, s_by, s_fh, s_fv;
  logic d_ack, d_exist, d_expl, d_blink, d_pulse;
  logic [10:0] d_bx, d_by, d_fh, d_fv;
  logic w_ack, w_exist, w_expl, w_blink, w_pulse;
  logic [10:0] w_bx, w_by, w_fh, w_fv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bomb_fuse_ctrl #(.FUSE_FRAMES(4), .FLAME_FRAMES(3), .COOLDOWN_FRAMES(2), .WARN_FRAMES(2)) u_small (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .place_req(place_req),
    .playerX(px), .playerY(py), .chain_hit(chain_hit),
    .place_ack(s_ack), .bomb_exist(s_exist), .bomb_exploded(s_expl), .bomb_blink(s_blink),
    .explode_pulse(s_pulse), .bombTopLeftX(s_bx), .bombTopLeftY(s_by),
    .flameHTopLeftX(s_fh), .flameVTopLeftY(s_fv));

  bomb_fuse_ctrl u_def (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .place_req(place_req),
    .playerX(px), .playerY(py), .chain_hit(chain_hit),
    .place_ack(d_ack), .bomb_exist(d_exist), .bomb_exploded(d_expl), .bomb_blink(d_blink),
    .explode_pulse(d_pulse), .bombTopLeftX(d_bx), .bombTopLeftY(d_by),
    .flameHTopLeftX(d_fh), .flameVTopLeftY(d_fv));

  bomb_fuse_ctrl #(.FUSE_FRAMES(70), .FLAME_FRAMES(3), .COOLDOWN_FRAMES(2), .WARN_FRAMES(60)) u_warn (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .place_req(place_req),
    .playerX(px), .playerY(py), .chain_hit(chain_hit),
    .place_ack(w_ack), .bomb_exist(w_exist), .bomb_exploded(w_expl), .bomb_blink(w_blink),
    .explode_pulse(w_pulse), .bombTopLeftX(w_bx), .bombTopLeftY(w_by),
    .flameHTopLeftX(w_fh), .flameVTopLeftY(w_fv));

  typedef struct {
    logic [10:0] px, py, bx, by, fh, fv;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; place_req = 1'b0; chain_hit = 1'b0; sof = 1'b0;
    tick();
    resetN = 1'b1;
  endtask

  task automatic frame();
    sof = 1'b1; tick();
    sof = 1'b0; tick();
  endtask

  task automatic place(input logic [10:0] x, input logic [10:0] y);
    px = x; py = y; place_req = 1'b1;
    tick();
    place_req = 1'b0;
  endtask

  initial begin
    int acks;
    int sofs;
    int sof_at_ack[2];
    logic [7:0] cnt;

    vecs[0] = '{11'd50,   11'd70,   11'd64,  11'd64,   11'd32,  11'd32};
    vecs[1] = '{11'd5,    11'd10,   11'd0,   11'd0,    11'd0,   11'd0};
    vecs[2] = '{11'd0,    11'd0,    11'd0,   11'd0,    11'd0,   11'd0};
    vecs[3] = '{11'd16,   11'd47,   11'd32,  11'd32,   11'd0,   11'd0};
    vecs[4] = '{11'd2040, 11'd2000, 11'd0,   11'd2016, 11'd0,   11'd1984};
    vecs[5] = '{11'd100,  11'd300,  11'd96,  11'd288,  11'd64,  11'd256};
    vecs[6] = '{11'd2047, 11'd2047, 11'd0,   11'd0,    11'd0,   11'd0};
    vecs[7] = '{11'd1000, 11'd47,   11'd992, 11'd32,   11'd960, 11'd0};

    // Reset state of every instance.
    do_reset();
    chk("rst_ack", {31'd0, s_ack}, 32'd0);
    chk("rst_exist", {31'd0, s_exist | d_exist | w_exist}, 32'd0);
    chk("rst_exploded", {31'd0, s_expl | d_expl | w_expl}, 32'd0);
    chk("rst_pulse", {31'd0, s_pulse | d_pulse | w_pulse}, 32'd0);
    chk("rst_blink", {29'd0, s_blink, d_blink, w_blink}, 32'd7);
    chk("rst_pos", {10'd0, s_bx, s_fh}, 32'd0);

    // Placement snapping table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      place(vecs[i].px, vecs[i].py);
      chk($sformatf("v%0d_ack", i), {31'd0, s_ack}, 32'd1);
      chk($sformatf("v%0d_exist", i), {31'd0, s_exist}, 32'd1);
      chk($sformatf("v%0d_bx", i), {21'd0, s_bx}, {21'd0, vecs[i].bx});
      chk($sformatf("v%0d_by", i), {21'd0, s_by}, {21'd0, vecs[i].by});
      chk($sformatf("v%0d_fh", i), {21'd0, s_fh}, {21'd0, vecs[i].fh});
      chk($sformatf("v%0d_fv", i), {21'd0, s_fv}, {21'd0, vecs[i].fv});
    end

    // Short fuse life cycle, ignored requests, request held through cooldown.
    do_reset();
    place(11'd50, 11'd70);
    chk("life_ack", {31'd0, s_ack}, 32'd1);
    tick();
    chk("life_ack_width", {31'd0, s_ack}, 32'd0);
    px = 11'd500; place_req = 1'b1;
    tick();
    place_req = 1'b0;
    chk("armed_req_ack", {31'd0, s_ack}, 32'd0);
    chk("armed_req_bx", {21'd0, s_bx}, 32'd64);
    frame(); frame(); frame();
    chk("fuse3_exploded", {31'd0, s_expl}, 32'd0);
    chk("fuse3_exist", {31'd0, s_exist}, 32'd1);
    sof = 1'b1; tick();
    chk("fuse4_exploded", {31'd0, s_expl}, 32'd1);
    chk("fuse4_pulse", {31'd0, s_pulse}, 32'd1);
    sof = 1'b0; tick();
    chk("pulse_width", {31'd0, s_pulse}, 32'd0);
    chain_hit = 1'b1; tick(); chain_hit = 1'b0;
    chk("chain_in_expl_pulse", {31'd0, s_pulse}, 32'd0);
    frame(); frame();
    chk("flame2_exploded", {31'd0, s_expl}, 32'd1);
    frame();
    chk("cool_exploded", {31'd0, s_expl}, 32'd0);
    chk("cool_exist", {31'd0, s_exist}, 32'd0);
    place_req = 1'b1;
    frame();
    sof = 1'b1; tick();
    chk("cool_end_ack", {31'd0, s_ack}, 32'd0);
    sof = 1'b0; tick();
    chk("idle_ack", {31'd0, s_ack}, 32'd1);
    chk("idle_bx", {21'd0, s_bx}, 32'd512);
    place_req = 1'b0;

    // Reset during EXPLODING, with every other input active, then a fresh placement.
    frame(); frame(); frame(); frame();
    chk("pre_rst_exploded", {31'd0, s_expl}, 32'd1);
    resetN = 1'b0; place_req = 1'b1; chain_hit = 1'b1; sof = 1'b1;
    tick();
    resetN = 1'b1; chain_hit = 1'b0; sof = 1'b0;
    chk("rst_expl_outs", {26'd0, s_ack, s_exist, s_expl, s_pulse, s_blink}, 32'd1);
    chk("rst_expl_pos", {s_bx, s_by, 10'd0} | {21'd0, s_fh} | {21'd0, s_fv}, 32'd0);
    tick();
    place_req = 1'b0;
    chk("post_rst_ack", {31'd0, s_ack}, 32'd1);
    chk("post_rst_exist", {31'd0, s_exist}, 32'd1);

    // Chain hit with 100 frames of fuse left (default timings).
    do_reset();
    place(11'd50, 11'd70);
    for (int i = 0; i < 80; i++) frame();
    chk("ch_pre_exploded", {31'd0, d_expl}, 32'd0);
    chain_hit = 1'b1; tick(); chain_hit = 1'b0;
    chk("ch_pulse", {31'd0, d_pulse}, 32'd1);
    chk("ch_exploded", {31'd0, d_expl}, 32'd1);
    chk("ch_exist", {31'd0, d_exist}, 32'd1);
    tick();
    chk("ch_pulse_width", {31'd0, d_pulse}, 32'd0);

    // Chain hit coinciding with a frame pulse.
    do_reset();
    place(11'd50, 11'd70);
    chain_hit = 1'b1; sof = 1'b1; tick(); chain_hit = 1'b0; sof = 1'b0;
    chk("ch_sof_exploded", {31'd0, d_expl}, 32'd1);

    // Chain hit in IDLE is ignored.
    do_reset();
    chain_hit = 1'b1; tick(); chain_hit = 1'b0;
    chk("ch_idle", {29'd0, d_exist, d_expl, d_pulse}, 32'd0);

    // Held request with default timings: one ack per 220 frames.
    do_reset();
    place_req = 1'b1;
    acks = 0; sofs = 0; sof_at_ack[0] = 0; sof_at_ack[1] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      sof = (cyc % 3 == 2) ? 1'b1 : 1'b0;
      tick();
      if (sof) sofs++;
      if (d_ack) begin
        if (acks < 2) sof_at_ack[acks] = sofs;
        acks++;
      end
    end
    place_req = 1'b0; sof = 1'b0;
    chk("held_ack_count", acks, 32'd2);
    chk("held_ack_spacing", sof_at_ack[1] - sof_at_ack[0], 32'd220);

    // Fuse-warning blink with FUSE_FRAMES=70, WARN_FRAMES=60.
    do_reset();
    place(11'd50, 11'd70);
    chk("blink_k0", {31'd0, w_blink}, 32'd1);
    for (int k = 1; k < 70; k++) begin
      sof = 1'b1; tick();
      cnt = 8'(70 - k);
      chk($sformatf("blink_k%0d", k), {31'd0, w_blink}, (cnt > 8'd60) ? 32'd1 : {31'd0, cnt[3]});
      sof = 1'b0; tick();
    end
    sof = 1'b1; tick(); sof = 1'b0;
    chk("blink_expl", {30'd0, w_expl, w_blink}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
